// File: rtl/pe_mac_engine_pkg.sv
// pe_mac_engine_pkg: shared state encoding and default sizing for the PE lane.
package pe_mac_engine_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PUSH, FIN} pe_state_t;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 20;
    localparam int DEF_MAX_DIM = 8;
    localparam int DEF_NUM_PE  = 4;
    localparam int DEF_ADDR_W  = 6;
endpackage

// File: rtl/pe_mac_engine_mac.sv
// pe_mac_unit: registered multiply-accumulate with clear.
// PE_SAT_EN defined: saturate at 2^ACC_W-1; otherwise wrap modulo 2^ACC_W.
module pe_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    acc_nxt;

    always_comb begin
        prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        sum  = {1'b0, acc} + (ACC_W+1)'(prod);
`ifdef PE_SAT_EN
        // products are non-negative, so once pinned at all-ones the row stays there
        acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_nxt;
    end
endmodule

// File: rtl/pe_mac_engine.sv
// pe_mac_engine: one matrix x vector lane computing rows p_num, p_num+NUM_PE, ...
// Accumulator overflow behaviour selected by PE_SAT_EN (see pe_mac_unit).
module pe_mac_engine
    import pe_mac_engine_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_DIM = DEF_MAX_DIM,
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        mat_size,
    input  logic [2:0]        p_num,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [2:0]        vec_addr,
    input  logic [DATA_W-1:0] vec_data,
    input  logic [ACC_W-1:0]  max_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [2:0]        res_row,
    output logic [ACC_W-1:0]  max_out,
    output logic              busy,
    output logic              done
);
    localparam int KW = $clog2(MAX_DIM);
    localparam int RW = $clog2(MAX_DIM + NUM_PE);

    pe_state_t        state, state_nxt;
    logic [3:0]       n;
    logic [RW-1:0]    row, row_nxt;
    logic [KW-1:0]    k;
    logic [ACC_W-1:0] acc, cand, m1, mx;
    logic             st, empty, last_k, xfer, rows_done;

    pe_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(state == FETCH && k == '0),
        .en((state == FETCH && k != '0) || state == DRAIN),
        .a(ram_data),
        .b(vec_data),
        .acc(acc)
    );

    always_comb begin
        st        = state == IDLE && start;
        empty     = mat_size == 4'd0 || 32'(mat_size) > MAX_DIM || {1'b0, p_num} >= mat_size;
        last_k    = 32'(k) == 32'(n) - 1;
        xfer      = state == PUSH && res_ready;
        row_nxt   = row + RW'(NUM_PE);
        rows_done = 32'(row_nxt) >= 32'(n);
        cand      = xfer ? acc : '0;
        m1        = max_in > max_out ? max_in : max_out;
        mx        = cand > m1 ? cand : m1;
        res_valid = state == PUSH;
        res_data  = acc;
        res_row   = 3'(row);
        ram_addr  = state == FETCH ? ADDR_W'(32'(row) * 32'(n) + 32'(k)) : '0;
        vec_addr  = state == FETCH ? 3'(k) : 3'd0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = st ? (empty ? FIN : FETCH) : IDLE;
            FETCH:   state_nxt = last_k ? DRAIN : FETCH;
            DRAIN:   state_nxt = PUSH;
            PUSH:    state_nxt = res_ready ? (rows_done ? FIN : FETCH) : PUSH;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            n       <= '0;
            row     <= '0;
            k       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            max_out <= '0;
        end else begin
            state   <= state_nxt;
            done    <= state == FIN;
            max_out <= st ? '0 : mx;
            if (st) begin
                n    <= mat_size;
                row  <= RW'(p_num);
                k    <= '0;
                busy <= 1'b1;
            end
            if (state == FIN)
                busy <= 1'b0;
            if (state == FETCH)
                k <= last_k ? '0 : k + 1'b1;
            if (xfer)
                row <= row_nxt;
        end
    end
endmodule
